// File: rtl/pc_fetch.sv
// Program-counter / fetch-sequencing stage: holds the PC, sequences idle/run/halt, qualifies fetches.
// Optional PC_FETCH_CYCLE_COUNT_EN adds a saturating run-cycle counter output (cycle_count).
//
// state  | meaning
// S_IDLE | waiting for start; pc parked at START_PC, no fetch
// S_RUN  | fetching; pc advances to next_pc_in unless stalled or halting
// S_HALT | halt decoded; pc holds the halt address, done asserted until start
module pc_fetch #(
  parameter int                  PC_WIDTH = 16,
  parameter logic [PC_WIDTH-1:0] START_PC = '0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [PC_WIDTH-1:0] next_pc_in,
  input  logic                stall,
  input  logic                halt_req,
  output logic [PC_WIDTH-1:0] pc,
  output logic [PC_WIDTH-1:0] pc_plus1,
  output logic                fetch_valid,
`ifdef PC_FETCH_CYCLE_COUNT_EN
  output logic [31:0]         cycle_count,
`endif
  output logic                done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      pc    <= START_PC;
      done  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          pc   <= START_PC;
          done <= 1'b0;
          if (start) state <= S_RUN;
        end
        S_RUN: begin
          // halt wins over stall: the halt address must stay visible in pc
          if (halt_req) begin
            state <= S_HALT;
            done  <= 1'b1;
          end else if (!stall) begin
            pc <= next_pc_in;
          end
        end
        S_HALT: begin
          if (start) begin
            state <= S_RUN;
            pc    <= START_PC;
            done  <= 1'b0;
          end
        end
        default: begin
          state <= S_IDLE;
          pc    <= START_PC;
          done  <= 1'b0;
        end
      endcase
    end
  end

  assign pc_plus1    = pc + {{(PC_WIDTH-1){1'b0}}, 1'b1};
  assign fetch_valid = (state == S_RUN) && !stall;

`ifdef PC_FETCH_CYCLE_COUNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_count <= 32'd0;
    end else if (state == S_RUN) begin
      if (cycle_count != 32'hFFFF_FFFF) cycle_count <= cycle_count + 32'd1;
    end else if (start) begin
      cycle_count <= 32'd0;
    end
  end
`endif

endmodule

// File: tb/tb_pc_fetch.sv
// Self-checking bench for pc_fetch: a behavioural model pushes expected state per driven cycle,
// each scenario task pops and compares after the clock edge.
module tb_pc_fetch;
  localparam int             W   = 16;
  localparam logic [W-1:0]   SPC = '0;

  logic         clk = 1'b0;
  logic         reset, start, stall, halt_req;
  logic [W-1:0] next_pc_in, pc, pc_plus1;
  logic         fetch_valid, done;
`ifdef PC_FETCH_CYCLE_COUNT_EN
  logic [31:0]  cycle_count;
`endif

  int n_cmp = 0;
  int n_err = 0;

  typedef enum {M_IDLE, M_RUN, M_HALT} mst_t;
  typedef struct {
    logic [W-1:0] pc;
    logic [W-1:0] pc1;
    logic         done;
    logic         fv;
    logic [31:0]  cnt;
  } exp_t;

  mst_t         m_state;
  logic [W-1:0] m_pc;
  logic         m_done;
  logic [31:0]  m_cnt;
  exp_t         sb[$];

  pc_fetch #(.PC_WIDTH(W), .START_PC(SPC)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .next_pc_in  (next_pc_in),
    .stall       (stall),
    .halt_req    (halt_req),
    .pc          (pc),
    .pc_plus1    (pc_plus1),
    .fetch_valid (fetch_valid),
`ifdef PC_FETCH_CYCLE_COUNT_EN
    .cycle_count (cycle_count),
`endif
    .done        (done)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_state = M_IDLE;
    m_pc    = SPC;
    m_done  = 1'b0;
    m_cnt   = 32'd0;
    sb.delete();
  endtask

  // Drive one cycle of inputs at the falling edge, predict the post-edge state, wait past the rising edge.
  task automatic drive_cycle(input logic st, input logic sl, input logic hr, input logic [W-1:0] npc);
    exp_t e;
    @(negedge clk);
    start = st; stall = sl; halt_req = hr; next_pc_in = npc;
    case (m_state)
      M_IDLE: if (st) begin m_state = M_RUN; m_pc = SPC; m_cnt = 32'd0; end
      M_RUN: begin
        if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
        if (hr) begin m_state = M_HALT; m_done = 1'b1; end
        else if (!sl) m_pc = npc;
      end
      M_HALT: if (st) begin m_state = M_RUN; m_pc = SPC; m_done = 1'b0; m_cnt = 32'd0; end
      default: m_state = M_IDLE;
    endcase
    e.pc = m_pc; e.pc1 = m_pc + 16'd1; e.done = m_done;
    e.fv = (m_state == M_RUN) && !sl; e.cnt = m_cnt;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    reset = 1'b1; start = 1'b0; stall = 1'b0; halt_req = 1'b0; next_pc_in = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (pc !== SPC)         begin n_err++; $display("FAIL reset_pc got %h want %h", pc, SPC); end
    n_cmp++; if (fetch_valid !== 1'b0) begin n_err++; $display("FAIL reset_fv got %b want 0", fetch_valid); end
    n_cmp++; if (done !== 1'b0)      begin n_err++; $display("FAIL reset_done got %b want 0", done); end
    @(negedge clk); reset = 1'b0;
    // IDLE ignores everything but start
    drive_cycle(1'b0, 1'b1, 1'b1, 16'h1234);
    drive_cycle(1'b0, 1'b0, 1'b0, 16'h4321);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      n_cmp++; if (pc !== e.pc)          begin n_err++; $display("FAIL idle_pc got %h want %h", pc, e.pc); end
      n_cmp++; if (fetch_valid !== e.fv) begin n_err++; $display("FAIL idle_fv got %b want %b", fetch_valid, e.fv); end
    end
  endtask

  task automatic test_sequential();
    exp_t e;
    drive_cycle(1'b1, 1'b0, 1'b0, 16'h7777);
    e = sb.pop_front();
    n_cmp++; if (pc !== 16'h0000 || pc !== e.pc) begin n_err++; $display("FAIL first_fetch_pc got %h want %h", pc, e.pc); end
    n_cmp++; if (fetch_valid !== 1'b1) begin n_err++; $display("FAIL first_fetch_fv got %b want 1", fetch_valid); end
    for (int i = 0; i < 4; i++) begin
      drive_cycle(1'b0, 1'b0, 1'b0, m_pc + 16'd1);
      e = sb.pop_front();
      n_cmp++; if (pc !== e.pc)          begin n_err++; $display("FAIL seq_pc[%0d] got %h want %h", i, pc, e.pc); end
      n_cmp++; if (fetch_valid !== e.fv) begin n_err++; $display("FAIL seq_fv[%0d] got %b want %b", i, fetch_valid, e.fv); end
      n_cmp++; if (pc_plus1 !== e.pc1)   begin n_err++; $display("FAIL seq_pc1[%0d] got %h want %h", i, pc_plus1, e.pc1); end
    end
    n_cmp++; if (pc !== 16'h0004) begin n_err++; $display("FAIL seq_end_pc got %h want 0004", pc); end
    // start while running must not restart
    drive_cycle(1'b1, 1'b0, 1'b0, 16'h0020);
    e = sb.pop_front();
    n_cmp++; if (pc !== e.pc) begin n_err++; $display("FAIL run_start_ignored got %h want %h", pc, e.pc); end
  endtask

  task automatic test_stall();
    exp_t e;
    logic [18:0] s [4];
    s = '{{3'b000, 16'h0003}, {3'b010, 16'h0040}, {3'b010, 16'h0040}, {3'b000, 16'h0040}};
    for (int i = 0; i < 4; i++) begin
      drive_cycle(s[i][18], s[i][17], s[i][16], s[i][15:0]);
      e = sb.pop_front();
      n_cmp++; if (pc !== e.pc)          begin n_err++; $display("FAIL stall_pc[%0d] got %h want %h", i, pc, e.pc); end
      n_cmp++; if (fetch_valid !== e.fv) begin n_err++; $display("FAIL stall_fv[%0d] got %b want %b", i, fetch_valid, e.fv); end
      n_cmp++; if (done !== e.done)      begin n_err++; $display("FAIL stall_done[%0d] got %b want %b", i, done, e.done); end
    end
    n_cmp++; if (pc !== 16'h0040) begin n_err++; $display("FAIL stall_release_pc got %h want 0040", pc); end
  endtask

  task automatic test_halt();
    exp_t e;
    logic [18:0] s [5];
    s = '{{3'b000, 16'h0007}, {3'b011, 16'h0099}, {3'b000, 16'h0055}, {3'b011, 16'h0055}, {3'b100, 16'h0055}};
    for (int i = 0; i < 5; i++) begin
      drive_cycle(s[i][18], s[i][17], s[i][16], s[i][15:0]);
      e = sb.pop_front();
      n_cmp++; if (pc !== e.pc)          begin n_err++; $display("FAIL halt_pc[%0d] got %h want %h", i, pc, e.pc); end
      n_cmp++; if (fetch_valid !== e.fv) begin n_err++; $display("FAIL halt_fv[%0d] got %b want %b", i, fetch_valid, e.fv); end
      n_cmp++; if (done !== e.done)      begin n_err++; $display("FAIL halt_done[%0d] got %b want %b", i, done, e.done); end
      if (i == 2) begin
        n_cmp++; if (pc !== 16'h0007 || done !== 1'b1) begin n_err++; $display("FAIL halt_hold got pc=%h done=%b want pc=0007 done=1", pc, done); end
      end
    end
  endtask

  task automatic test_wrap();
    exp_t e;
    drive_cycle(1'b0, 1'b0, 1'b0, 16'hFFFF);
    e = sb.pop_front();
    n_cmp++; if (pc !== e.pc)        begin n_err++; $display("FAIL wrap_pc got %h want %h", pc, e.pc); end
    n_cmp++; if (pc_plus1 !== 16'h0000) begin n_err++; $display("FAIL wrap_pc1 got %h want 0000", pc_plus1); end
    drive_cycle(1'b0, 1'b0, 1'b0, m_pc + 16'd1);
    e = sb.pop_front();
    n_cmp++; if (pc !== e.pc)        begin n_err++; $display("FAIL wrap_adv_pc got %h want %h", pc, e.pc); end
    n_cmp++; if (pc_plus1 !== e.pc1) begin n_err++; $display("FAIL wrap_adv_pc1 got %h want %h", pc_plus1, e.pc1); end
  endtask

  task automatic test_reset_mid_run();
    exp_t e;
    drive_cycle(1'b0, 1'b0, 1'b0, 16'h0005);
    e = sb.pop_front();
    n_cmp++; if (pc !== e.pc) begin n_err++; $display("FAIL pre_reset_pc got %h want %h", pc, e.pc); end
    @(negedge clk); #2;
    reset = 1'b1;
    #1;
    n_cmp++; if (pc !== SPC)          begin n_err++; $display("FAIL async_reset_pc got %h want %h", pc, SPC); end
    n_cmp++; if (fetch_valid !== 1'b0) begin n_err++; $display("FAIL async_reset_fv got %b want 0", fetch_valid); end
    n_cmp++; if (done !== 1'b0)       begin n_err++; $display("FAIL async_reset_done got %b want 0", done); end
    @(negedge clk); reset = 1'b0;
    model_reset();
    drive_cycle(1'b0, 1'b0, 1'b0, 16'h0033);
    e = sb.pop_front();
    n_cmp++; if (pc !== e.pc || fetch_valid !== e.fv) begin n_err++; $display("FAIL post_reset_idle got pc=%h fv=%b want pc=%h fv=%b", pc, fetch_valid, e.pc, e.fv); end
  endtask

`ifdef PC_FETCH_CYCLE_COUNT_EN
  task automatic test_cycle_count();
    exp_t e;
    logic [18:0] s [9];
    s = '{{3'b100, 16'h0000}, {3'b000, 16'h0001}, {3'b010, 16'h0009}, {3'b000, 16'h0002},
          {3'b010, 16'h0009}, {3'b001, 16'h0009}, {3'b000, 16'h0000}, {3'b000, 16'h0000},
          {3'b100, 16'h0000}};
    for (int i = 0; i < 9; i++) begin
      drive_cycle(s[i][18], s[i][17], s[i][16], s[i][15:0]);
      e = sb.pop_front();
      n_cmp++; if (cycle_count !== e.cnt) begin n_err++; $display("FAIL cnt[%0d] got %0d want %0d", i, cycle_count, e.cnt); end
      n_cmp++; if (pc !== e.pc)           begin n_err++; $display("FAIL cnt_pc[%0d] got %h want %h", i, pc, e.pc); end
      if (i == 7) begin
        n_cmp++; if (cycle_count !== 32'd5) begin n_err++; $display("FAIL cnt_halt_frozen got %0d want 5", cycle_count); end
      end
    end
    n_cmp++; if (cycle_count !== 32'd0) begin n_err++; $display("FAIL cnt_restart got %0d want 0", cycle_count); end
  endtask
`endif

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_halt();
    test_wrap();
    test_reset_mid_run();
`ifdef PC_FETCH_CYCLE_COUNT_EN
    test_cycle_count();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
